sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-port round-robin burst arbiter in front of an Avalon-MM SDRAM controller with read-owner tracking.
// Define SDRAM_ARB_URGENT_EN to let `urgent` override round-robin (lowest urgent index wins).
module sdram_port_arbiter #(
  parameter int unsigned BL        = 256,
  parameter int unsigned OWN_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  req_wr,
  input  logic [71:0] req_addr,
  input  logic [2:0]  urgent,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  input  logic [47:0] wdata,
  output logic [2:0]  wdata_ack,
  output logic [15:0] rdata,
  output logic [2:0]  rdata_vld,
  output logic        rd_orphan,
  output logic        avm_write,
  output logic        avm_read,
  output logic [23:0] avm_addr,
  output logic [15:0] avm_wrdata,
  input  logic [15:0] avs_rddata,
  input  logic        avs_rddata_vld,
  input  logic        avs_waitrequest
);

  localparam int unsigned NP  = 3;
  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = (BL > 1) ? $clog2(BL) : 1;
  localparam int unsigned IW  = (OWN_DEPTH > 1) ? $clog2(OWN_DEPTH) : 1;
  localparam int unsigned OCW = $clog2(OWN_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic [NP-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   base_q, base_d;
  logic            wr_q, wr_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      own_q [OWN_DEPTH];
  logic [1:0]      own_d [OWN_DEPTH];
  logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OCW-1:0]  occ_q, occ_d;
  logic [CW-1:0]   rbeat_q, rbeat_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NP-1:0]   rdata_vld_q, rdata_vld_d;
  logic            orphan_q, orphan_d;

  logic [NP-1:0]   elig;
  logic            full, found, accept, last_beat, push, pop, route;
  logic [1:0]      pick, cand;

`ifndef SDRAM_ARB_URGENT_EN
  logic unused_urgent;
  assign unused_urgent = ^urgent;
`endif

  // Grantee selection: reads are held back while every owner slot is taken.
  always_comb begin
    full  = (occ_q == OCW'(OWN_DEPTH));
    elig  = req & (req_wr | {NP{~full}});
    found = 1'b0;
    pick  = '0;
    cand  = '0;
`ifdef SDRAM_ARB_URGENT_EN
    for (int i = 0; i < int'(NP); i++) begin
      if (!found && elig[2'(i)] && urgent[2'(i)]) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end
`endif
    for (int k = 1; k <= int'(NP); k++) begin
      cand = 2'((int'(last_q) + k) % int'(NP));
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign accept    = (state_q == XFER) && !avs_waitrequest;
  assign last_beat = (cnt_q == CW'(BL - 1));

  // Burst FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    wr_d    = wr_q;
    last_d  = last_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = XFER;
          gnt_d   = 3'b001 << pick;
          base_d  = req_addr[int'(pick)*AW +: AW];
          wr_d    = req_wr[pick];
          last_d  = pick;
          push    = !req_wr[pick];
        end
      end
      XFER: begin
        if (accept) begin
          cnt_d = last_beat ? '0 : cnt_q + CW'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner FIFO: head owns incoming read beats until BL of them have been routed.
  always_comb begin
    route       = avs_rddata_vld && (occ_q != '0);
    pop         = route && (rbeat_q == CW'(BL - 1));
    own_d       = own_q;
    tail_d      = tail_q;
    head_d      = head_q;
    occ_d       = occ_q;
    rbeat_d     = rbeat_q;
    rdata_d     = rdata_q;
    rdata_vld_d = '0;
    orphan_d    = orphan_q | (avs_rddata_vld && (occ_q == '0));
    if (push) begin
      own_d[tail_q] = pick;
      tail_d = (tail_q == IW'(OWN_DEPTH - 1)) ? '0 : tail_q + IW'(1);
    end
    if (pop) head_d = (head_q == IW'(OWN_DEPTH - 1)) ? '0 : head_q + IW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCW'(1);
      2'b01:   occ_d = occ_q - OCW'(1);
      default: occ_d = occ_q;
    endcase
    if (route) begin
      rbeat_d     = pop ? '0 : rbeat_q + CW'(1);
      rdata_d     = avs_rddata;
      rdata_vld_d = 3'b001 << own_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      wr_q        <= 1'b0;
      last_q      <= 2'd2;
      own_q       <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      rbeat_q     <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= '0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wr_q        <= wr_d;
      last_q      <= last_d;
      own_q       <= own_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      rbeat_q     <= rbeat_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      orphan_q    <= orphan_d;
    end
  end

  // Command side is a pure decode of the registered burst state.
  assign gnt        = gnt_q;
  assign done       = (state_q == DONE) ? gnt_q : '0;
  assign avm_write  = (state_q == XFER) && wr_q;
  assign avm_read   = (state_q == XFER) && !wr_q;
  assign avm_addr   = (state_q == XFER) ? base_q + AW'(cnt_q) : '0;
  assign avm_wrdata = avm_write ? wdata[int'(last_q)*DW +: DW] : '0;
  assign wdata_ack  = (accept && wr_q) ? gnt_q : '0;
  assign rdata      = rdata_q;
  assign rdata_vld  = rdata_vld_q;
  assign rd_orphan  = orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter against a burst/transaction-level reference model.
// Build with SDRAM_ARB_URGENT_EN defined to exercise the urgent override.
module tb_sdram_port_arbiter;

  localparam int BL    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_wr, urgent;
  logic [71:0] req_addr;
  logic [2:0]  gnt, done, wdata_ack, rdata_vld;
  logic [47:0] wdata;
  logic [15:0] rdata, avm_wrdata, avs_rddata;
  logic        rd_orphan, avm_write, avm_read, avs_rddata_vld, avs_waitrequest;
  logic [23:0] avm_addr;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.BL(BL), .OWN_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .urgent(urgent), .gnt(gnt), .done(done), .wdata(wdata), .wdata_ack(wdata_ack),
    .rdata(rdata), .rdata_vld(rdata_vld), .rd_orphan(rd_orphan),
    .avm_write(avm_write), .avm_read(avm_read), .avm_addr(avm_addr),
    .avm_wrdata(avm_wrdata), .avs_rddata(avs_rddata), .avs_rddata_vld(avs_rddata_vld),
    .avs_waitrequest(avs_waitrequest)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: burst phase 0=idle 1=transfer 2=done.
  int          m_phase = 0, m_g = 0, m_k = 0, m_last = 2;
  bit          m_wr = 1'b0, m_orphan = 1'b0;
  logic [23:0] m_base = '0;
  int          own_q[$];
  int          own_beats = 0, pending = 0;
  logic [2:0]  exp_rvld = '0;
  logic [15:0] exp_rdata = '0;
  logic [2:0]  p_req = '0, p_wr = '0;
  logic [71:0] p_addr = '0;
  bit          p_full = 1'b0, p_rst = 1'b1;
`ifdef SDRAM_ARB_URGENT_EN
  logic [2:0]  p_urg = '0;
`endif
  logic [15:0] wd [3];

  // Grant rule: urgent (optional) lowest index, else round-robin from last+1.
  function automatic int rr_pick(input logic [2:0] r, input logic [2:0] w, input bit fl, input int last);
    logic [2:0] el;
    int idx;
    for (int i = 0; i < 3; i++) el[2'(i)] = r[2'(i)] && (w[2'(i)] || !fl);
`ifdef SDRAM_ARB_URGENT_EN
    for (int i = 0; i < 3; i++) if (el[2'(i)] && p_urg[2'(i)]) return i;
`endif
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (el[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    int pk;
    logic [2:0] eg;
    if (p_rst) m_phase = 0;
    else if (m_phase == 2) m_phase = 0;
    else if (m_phase == 1 && m_k == BL) m_phase = 2;
    else if (m_phase == 0) begin
      pk = rr_pick(p_req, p_wr, p_full, m_last);
      if (pk >= 0) begin
        m_phase = 1; m_g = pk; m_k = 0; m_last = pk;
        m_wr = p_wr[2'(pk)];
        m_base = p_addr[pk*24 +: 24];
        if (!m_wr) begin own_q.push_back(pk); pending += BL; end
      end
    end
    eg = (m_phase == 0) ? 3'b000 : (3'b001 << m_g);
    chk_eq("gnt", 32'(gnt), 32'(eg));
    chk_eq("done", 32'(done), 32'((m_phase == 2) ? eg : 3'b000));
    chk_eq("avm_write", 32'(avm_write), 32'(m_phase == 1 && m_wr));
    chk_eq("avm_read", 32'(avm_read), 32'(m_phase == 1 && !m_wr));
    if (m_phase == 1) begin
      chk_eq("avm_addr", 32'(avm_addr), 32'(24'(m_base + 24'(m_k))));
      chk_eq("avm_wrdata", 32'(avm_wrdata), 32'(m_wr ? wd[m_g] : 16'h0));
      chk_eq("wdata_ack", 32'(wdata_ack), 32'((m_wr && !avs_waitrequest) ? eg : 3'b000));
      if (!avs_waitrequest) m_k++;
    end else begin
      chk_eq("wdata_ack_idle", 32'(wdata_ack), 32'(0));
      chk_eq("avm_wrdata_idle", 32'(avm_wrdata), 32'(0));
    end
    chk_eq("rdata_vld", 32'(rdata_vld), 32'(exp_rvld));
    chk_eq("rdata", 32'(rdata), 32'(exp_rdata));
    chk_eq("rd_orphan", 32'(rd_orphan), 32'(m_orphan));

    p_full = (own_q.size() == DEPTH);
    exp_rvld = '0;
    if (avs_rddata_vld) begin
      if (own_q.size() > 0) begin
        exp_rvld = 3'b001 << own_q[0];
        exp_rdata = avs_rddata;
        own_beats++;
        if (own_beats == BL) begin void'(own_q.pop_front()); own_beats = 0; end
      end else m_orphan = 1'b1;
    end
    p_req = req; p_wr = req_wr; p_addr = req_addr; p_rst = rst;
`ifdef SDRAM_ARB_URGENT_EN
    p_urg = urgent;
`endif
    if (rst) begin
      own_q.delete(); own_beats = 0; m_orphan = 1'b0;
      exp_rvld = '0; exp_rdata = '0; m_last = 2; m_phase = 0;
    end
  endtask

  typedef struct {int n; int preq; int pwr; int pwait; int pret; int porph; int purg; int prst;} knob_t;
  knob_t kt[5] = '{
    '{300, 100, 100,  0, 50, 0,  0, 0},
    '{600,  60,  50, 50, 40, 0, 20, 0},
    '{600,  90,  15, 10,  5, 0, 20, 0},
    '{400,  50,  50, 30, 50, 5, 30, 2},
    '{600,  70,  40, 20, 30, 2, 40, 6}
  };

  task automatic cycle(input knob_t k);
    @(negedge clk);
    rst = ($urandom_range(999) < k.prst);
    for (int i = 0; i < 3; i++) begin
      req[2'(i)]    = ($urandom_range(99) < k.preq);
      req_wr[2'(i)] = ($urandom_range(99) < k.pwr);
      urgent[2'(i)] = ($urandom_range(99) < k.purg);
      req_addr[i*24 +: 24] = $urandom_range(1) ? 24'hFFFFFC + 24'($urandom_range(3)) : 24'($urandom);
    end
    wdata = {wd[2], wd[1], wd[0]};
    avs_waitrequest = ($urandom_range(99) < k.pwait);
    avs_rddata = 16'($urandom);
    avs_rddata_vld = 1'b0;
    if (pending > 0) begin
      if ($urandom_range(99) < k.pret) begin avs_rddata_vld = 1'b1; pending--; end
    end else if ($urandom_range(99) < k.porph) avs_rddata_vld = 1'b1;
    #1;
    step();
    for (int i = 0; i < 3; i++) if (wdata_ack[2'(i)]) wd[i] = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_wr = '0; urgent = '0; req_addr = '0;
    avs_rddata = '0; avs_rddata_vld = 1'b0; avs_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) wd[i] = 16'($urandom);
    wdata = {wd[2], wd[1], wd[0]};
    repeat (3) @(posedge clk);
    for (int p = 0; p < 5; p++) repeat (kt[p].n) cycle(kt[p]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
